multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multicycle MIPS control unit. Replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several clocks.
- It sits between the instruction register opcode field and the shared datapath: one ALU, one unified memory, and the PC/IR/A/B/ALUOut registers.
- New relative to the single-cycle decoder: variable-latency memory handshake, JAL link writeback to $31, LUI ALU op, illegal-opcode trap, and a parametrised ALU-op width.

Parameters:
- ALUOP_W, 4, width of ALUOpSignal; must be >= 3; bits above [2:0] are driven 0.
- CNT_W, 32, width of the performance counters (Optional Feature only).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- InstrOpCode  in  6  opcode, IR[31:26]; sampled in DECODE only.
- MemReady  in  1  memory access completes this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if branch condition holds.
- BranchNe  out  1  0 = beq (take on Zero), 1 = bne (take on !Zero).
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load.
- RegDst  out  2  write register: 0 = rt, 1 = rd, 2 = $31.
- MemtoReg  out  2  write data: 0 = ALUOut, 1 = MDR, 2 = PC (link).
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2.
- ALUOpSignal  out  ALUOP_W  ALU operation.
- PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- InstrDone  out  1  one-cycle pulse in the final state of each instruction.
- Illegal  out  1  sticky trap flag.
- StateOut  out  4  current state encoding, for debug.

Behaviour:
- Outputs are a Moore function of state only; InstrOpCode affects only next-state and the latched op class.
- Reset: state = FETCH; Illegal = 0. Every output holds its FETCH value during and after rst.
- rst asserted mid-instruction aborts it in the next cycle: no further RegWrite, MemWrite or PCWrite.
- ALUOpSignal codes:
  - 0 add: address, PC+4, lw/sw
  - 1 sub: beq/bne
  - 2 funct: R-type
  - 3 addi/addiu
  - 4 andi
  - 5 ori
  - 6 slti/sltiu
  - 7 lui
- States and actions (all unlisted outputs 0):
  - FETCH (0): MemRead, IRWrite, ALUSrcB=1, PCWrite. IRWrite and PCWrite assert only while MemReady=1. Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
  - DECODE (1): ALUSrcB=3 (branch target into ALUOut). Latch the op class, then branch on opcode:
    - lw, lbu, lhu, sw, sh, sb -> MEMADR
    - R-type -> EXEC
    - addi, addiu, andi, ori, slti, sltiu, lui -> IEXEC
    - beq, bne -> BRANCH
    - j, jal -> JUMP
    - anything else -> ILLEGAL
  - MEMADR (2): ALUSrcA=1, ALUSrcB=2, ALUOp=0. Loads -> MEMRD; stores -> MEMWR.
  - MEMRD (3): MemRead, IorD=1. Hold while MemReady=0; go to MEMWB when MemReady=1.
  - MEMWB (4): RegWrite, MemtoReg=1, RegDst=0, InstrDone. Next FETCH.
  - MEMWR (5): MemWrite, IorD=1. Hold while MemReady=0. InstrDone asserts in the MemReady=1 cycle, then FETCH. MemWrite stays high for the whole wait.
  - EXEC (6): ALUSrcA=1, ALUSrcB=0, ALUOp=2. Next ALUWB.
  - ALUWB (7): RegWrite, plus InstrDone. R-type: RegDst=1, MemtoReg=0. Immediate ops: RegDst=0, MemtoReg=0. Next FETCH.
  - BRANCH (8): ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond, PCSource=1, BranchNe=(opcode==bne), InstrDone. Next FETCH.
  - JUMP (9): PCWrite, PCSource=2, InstrDone. For jal also RegWrite, RegDst=2, MemtoReg=2 (PC already holds PC+4). Next FETCH.
  - IEXEC (10): ALUSrcA=1, ALUSrcB=2, ALUOp per the op code table. Next ALUWB.
  - ILLEGAL (11): set Illegal; no strobes. Stay in ILLEGAL until rst.
- Latency with MemReady tied high:
  - R-type and immediate ops: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch and jump: 3 cycles
  - Each memory wait cycle adds 1.
- Encodings 12–15 are unreachable; if entered, go to FETCH next cycle.

Optional Feature:
- Macro: MCFSM_PERF_CNT_EN.
- When defined:
  - Adds outputs CycleCnt[CNT_W] and InstrCnt[CNT_W], both cleared by rst.
  - CycleCnt increments every non-reset cycle.
  - InstrCnt increments on each InstrDone.
  - Both counters wrap modulo 2^CNT_W.
  - Both freeze while in ILLEGAL.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles, then release with MemReady=1 and opcode 000000 -> StateOut 0,1,6,7,0; RegWrite=1, RegDst=1 only in state 7; InstrDone one pulse.
- lw (100011) with MemReady low for 3 cycles in MEMRD -> MemRead=1, IorD=1 held for 4 cycles; MEMWB has MemtoReg=1; total 8 cycles.
- jal (000011) -> JUMP asserts PCWrite, PCSource=2, RegWrite, RegDst=2, MemtoReg=2; with j (000010), RegWrite=0.
- bne (000101) -> BRANCH asserts PCWriteCond=1, BranchNe=1, ALUOpSignal=1; lui (001111) -> IEXEC ALUOpSignal=7, ALUSrcB=2.
- Opcode 111111 -> ILLEGAL; Illegal=1 sticky with no strobes for 10 cycles; rst clears it and returns to FETCH.
- sw with rst asserted during MEMWR -> MemWrite=0 the next cycle, StateOut=0. With MCFSM_PERF_CNT_EN, 3 R-type instructions give InstrCnt=3, CycleCnt=12.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/mem/writeback.
// Optional perf counters (CycleCnt/InstrCnt) under `MCFSM_PERF_CNT_EN`.
module multicycle_control_fsm #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         InstrOpCode,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNe,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOpSignal,
  output logic [1:0]         PCSource,
  output logic               InstrDone,
  output logic               Illegal,
  output logic [3:0]         StateOut
`ifdef MCFSM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   CycleCnt,
  output logic [CNT_W-1:0]   InstrCnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_ILLEGAL = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // The ALU op table needs three bits; narrower buses cannot encode it.
  if (ALUOP_W < 3) begin : g_aluop_w_chk
    $error("ALUOP_W must be at least 3");
  end

  // Counters need at least one bit to be meaningful.
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  state_t     state;
  state_t     state_nxt;

  logic       dec_load;
  logic       dec_store;
  logic       dec_rtype;
  logic       dec_imm;
  logic       dec_branch;
  logic       dec_jump;
  logic [2:0] dec_imm_op;

  logic       store_q;
  logic       rtype_q;
  logic       bne_q;
  logic       jal_q;
  logic [2:0] imm_op_q;

  logic [2:0] alu_op;

  // Opcode classification; only consumed while in DECODE.
  always_comb begin
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_rtype  = 1'b0;
    dec_imm    = 1'b0;
    dec_branch = 1'b0;
    dec_jump   = 1'b0;
    dec_imm_op = 3'd0;
    case (InstrOpCode)
      OP_RTYPE:               dec_rtype = 1'b1;
      OP_LW, OP_LBU, OP_LHU:  dec_load  = 1'b1;
      OP_SW, OP_SH, OP_SB:    dec_store = 1'b1;
      OP_ADDI, OP_ADDIU: begin
        dec_imm    = 1'b1;
        dec_imm_op = 3'd3;
      end
      OP_ANDI: begin
        dec_imm    = 1'b1;
        dec_imm_op = 3'd4;
      end
      OP_ORI: begin
        dec_imm    = 1'b1;
        dec_imm_op = 3'd5;
      end
      OP_SLTI, OP_SLTIU: begin
        dec_imm    = 1'b1;
        dec_imm_op = 3'd6;
      end
      OP_LUI: begin
        dec_imm    = 1'b1;
        dec_imm_op = 3'd7;
      end
      OP_BEQ, OP_BNE:         dec_branch = 1'b1;
      OP_J, OP_JAL:           dec_jump   = 1'b1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Op class latched in DECODE so later states see a stable variant.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_q  <= 1'b0;
      rtype_q  <= 1'b0;
      bne_q    <= 1'b0;
      jal_q    <= 1'b0;
      imm_op_q <= 3'd0;
    end else if (state == S_DECODE) begin
      store_q  <= dec_store;
      rtype_q  <= dec_rtype;
      bne_q    <= (InstrOpCode == OP_BNE);
      jal_q    <= (InstrOpCode == OP_JAL);
      imm_op_q <= dec_imm_op;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          dec_load,
          dec_store:  state_nxt = S_MEMADR;
          dec_rtype:  state_nxt = S_EXEC;
          dec_imm:    state_nxt = S_IEXEC;
          dec_branch: state_nxt = S_BRANCH;
          dec_jump:   state_nxt = S_JUMP;
          default:    state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_nxt = store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_nxt = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_nxt = S_FETCH;
      S_MEMWR:   state_nxt = MemReady ? S_FETCH : S_MEMWR;
      S_EXEC:    state_nxt = S_ALUWB;
      S_ALUWB:   state_nxt = S_FETCH;
      S_BRANCH:  state_nxt = S_FETCH;
      S_JUMP:    state_nxt = S_FETCH;
      S_IEXEC:   state_nxt = S_ALUWB;
      S_ILLEGAL: state_nxt = S_ILLEGAL;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Output decode from state and latched op class.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 2'd0;
    MemtoReg    = 2'd0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    alu_op      = 3'd0;
    PCSource    = 2'd0;
    InstrDone   = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = MemReady;
        PCWrite = MemReady;
        ALUSrcB = 2'd1;
      end
      S_DECODE: ALUSrcB = 2'd3;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 2'd1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = MemReady;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        alu_op  = 3'd2;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        RegDst    = rtype_q ? 2'd1 : 2'd0;
        InstrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        alu_op      = 3'd1;
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
        BranchNe    = bne_q;
        InstrDone   = 1'b1;
      end
      S_JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'd2;
        InstrDone = 1'b1;
        if (jal_q) begin
          RegWrite = 1'b1;
          RegDst   = 2'd2;
          MemtoReg = 2'd2;
        end
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        alu_op  = imm_op_q;
      end
      default: ;
    endcase
  end

  assign ALUOpSignal = ALUOP_W'(alu_op);
  assign Illegal     = (state == S_ILLEGAL);
  assign StateOut    = state;

`ifdef MCFSM_PERF_CNT_EN
  // Cycle and retired-instruction counters; frozen once trapped.
  always_ff @(posedge clk) begin
    if (rst) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else if (state != S_ILLEGAL) begin
      CycleCnt <= CycleCnt + 1'b1;
      if (InstrDone) InstrCnt <= InstrCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: vector table,
// directed corner sequences and a randomized reference-model run.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst;
  logic [5:0] InstrOpCode;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUOpSignal;
  logic [1:0] PCSource;
  logic       InstrDone;
  logic       Illegal;
  logic [3:0] StateOut;
`ifdef MCFSM_PERF_CNT_EN
  logic [31:0] CycleCnt;
  logic [31:0] InstrCnt;
`endif

  int checks;
  int failures;
  int plan[$];

  multicycle_control_fsm #(.ALUOP_W(4), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .InstrOpCode(InstrOpCode),
    .MemReady(MemReady),
    .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond),
    .BranchNe(BranchNe),
    .IorD(IorD),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .IRWrite(IRWrite),
    .RegDst(RegDst),
    .MemtoReg(MemtoReg),
    .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .ALUOpSignal(ALUOpSignal),
    .PCSource(PCSource),
    .InstrDone(InstrDone),
    .Illegal(Illegal),
    .StateOut(StateOut)
`ifdef MCFSM_PERF_CNT_EN
    ,
    .CycleCnt(CycleCnt),
    .InstrCnt(InstrCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    int         st2;
    int         lat;
    int         rw;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    MemReady = 1'b1;
    InstrOpCode = 6'd0;
    adv();
    adv();
    rst = 1'b0;
  endtask

  // Instruction classes: 0 illegal 1 load 2 store 3 rtype 4 imm 5 br 6 jmp
  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'h23, 6'h24, 6'h25:                     return 1;
      6'h2B, 6'h29, 6'h28:                     return 2;
      6'h00:                                   return 3;
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B,
      6'h0F:                                   return 4;
      6'h04, 6'h05:                            return 5;
      6'h02, 6'h03:                            return 6;
      default:                                 return 0;
    endcase
  endfunction

  function automatic int exp_imm_alu(input logic [5:0] op);
    case (op)
      6'h08, 6'h09: return 3;
      6'h0C:        return 4;
      6'h0D:        return 5;
      6'h0A, 6'h0B: return 6;
      6'h0F:        return 7;
      default:      return 0;
    endcase
  endfunction

  function automatic int writes_reg(input logic [5:0] op);
    int c;
    c = op_class(op);
    if (c == 1 || c == 3 || c == 4 || op == 6'h03) return 1;
    return 0;
  endfunction

  // Expected visited-state list for one instruction.
  task automatic build_plan(input logic [5:0] op);
    plan.delete();
    plan.push_back(0);
    plan.push_back(1);
    case (op_class(op))
      1: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
      2: begin plan.push_back(2); plan.push_back(5); end
      3: begin plan.push_back(6); plan.push_back(7); end
      4: begin plan.push_back(10); plan.push_back(7); end
      5: plan.push_back(8);
      6: plan.push_back(9);
      default: plan.push_back(11);
    endcase
  endtask

  // Run one instruction against the model with random memory stalls.
  task automatic run_model(input logic [5:0] op);
    int idx;
    int guard;
    int rw;
    int dn;
    int mw;
    int mw_exp;
    int ph;
    build_plan(op);
    idx = 0;
    guard = 0;
    rw = 0;
    dn = 0;
    mw = 0;
    mw_exp = 0;
    while (idx < plan.size() && guard < 200) begin
      InstrOpCode = op;
      MemReady = ($urandom_range(0, 99) >= 35);
      ph = plan[idx];
      @(negedge clk);
      chk("rnd_state", StateOut, ph);
      if (RegWrite) rw++;
      if (InstrDone) dn++;
      if (MemWrite) mw++;
      if (ph == 5) mw_exp++;
      if (ph == 10) chk("rnd_aluop", ALUOpSignal, exp_imm_alu(op));
      if (!((ph == 0 || ph == 3 || ph == 5) && !MemReady)) idx++;
      adv();
      guard++;
    end
    if (guard >= 200) chk("rnd_timeout", 1, 0);
    chk("rnd_regwrite", rw, writes_reg(op));
    chk("rnd_done", dn, 1);
    chk("rnd_memwrite", mw, mw_exp);
  endtask

  initial begin
    vec_t vt[12];
    logic [5:0] legal[17];
    int st2;
    int lat;
    int rw;
    int bad;
    int mrd;
    int cyc;
    logic [5:0] op;

    vt[0]  = '{6'h00, 6, 4, 1};
    vt[1]  = '{6'h23, 2, 5, 1};
    vt[2]  = '{6'h24, 2, 5, 1};
    vt[3]  = '{6'h2B, 2, 4, 0};
    vt[4]  = '{6'h28, 2, 4, 0};
    vt[5]  = '{6'h08, 10, 4, 1};
    vt[6]  = '{6'h0C, 10, 4, 1};
    vt[7]  = '{6'h0F, 10, 4, 1};
    vt[8]  = '{6'h04, 8, 3, 0};
    vt[9]  = '{6'h05, 8, 3, 0};
    vt[10] = '{6'h02, 9, 3, 0};
    vt[11] = '{6'h03, 9, 3, 1};

    legal = '{6'h00, 6'h23, 6'h24, 6'h25, 6'h2B, 6'h29, 6'h28, 6'h08,
              6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B, 6'h0F, 6'h04, 6'h05,
              6'h02};

    checks = 0;
    failures = 0;
    rst = 1'b1;
    MemReady = 1'b1;
    InstrOpCode = 6'd0;

    // Reset: FETCH outputs held during reset.
    adv();
    @(negedge clk);
    chk("rst_state", StateOut, 0);
    chk("rst_illegal", Illegal, 0);
    chk("rst_memread", MemRead, 1);
    chk("rst_alusrcb", ALUSrcB, 1);
    chk("rst_regwrite", RegWrite, 0);
    adv();
    rst = 1'b0;

    // R-type trace 0,1,6,7,0.
    begin
      int exp_st[5];
      int dn;
      exp_st = '{0, 1, 6, 7, 0};
      dn = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("rtype_state", StateOut, exp_st[i]);
        chk("rtype_regwrite", RegWrite, (exp_st[i] == 7) ? 1 : 0);
        chk("rtype_regdst", RegDst, (exp_st[i] == 7) ? 1 : 0);
        if (i < 4 && InstrDone) dn++;
        adv();
      end
      chk("rtype_done_pulses", dn, 1);
    end

    // Vector table, MemReady tied high.
    do_reset();
    for (int v = 0; v < 12; v++) begin
      st2 = -1;
      lat = 0;
      rw = 0;
      cyc = 0;
      InstrOpCode = vt[v].op;
      MemReady = 1'b1;
      while (lat == 0 && cyc < 20) begin
        @(negedge clk);
        if (cyc == 2) st2 = StateOut;
        if (RegWrite) rw++;
        if (InstrDone) lat = cyc + 1;
        adv();
        cyc++;
      end
      chk("vec_state2", st2, vt[v].st2);
      chk("vec_latency", lat, vt[v].lat);
      chk("vec_regwrite", rw, vt[v].rw);
    end

    // lw with three MEMRD wait cycles.
    do_reset();
    InstrOpCode = 6'h23;
    mrd = 0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      MemReady = !(i >= 3 && i <= 5);
      @(negedge clk);
      if (MemRead && IorD) mrd++;
      if (i == 7) begin
        chk("lw_wb_state", StateOut, 4);
        chk("lw_wb_memtoreg", MemtoReg, 1);
        chk("lw_wb_done", InstrDone, 1);
      end
      adv();
    end
    chk("lw_memrd_cycles", mrd, 4);

    // jal then j in JUMP.
    do_reset();
    InstrOpCode = 6'h03;
    adv();
    adv();
    @(negedge clk);
    chk("jal_state", StateOut, 9);
    chk("jal_pcwrite", PCWrite, 1);
    chk("jal_pcsource", PCSource, 2);
    chk("jal_regwrite", RegWrite, 1);
    chk("jal_regdst", RegDst, 2);
    chk("jal_memtoreg", MemtoReg, 2);
    adv();
    InstrOpCode = 6'h02;
    adv();
    adv();
    @(negedge clk);
    chk("j_pcwrite", PCWrite, 1);
    chk("j_regwrite", RegWrite, 0);
    adv();

    // bne BRANCH, then lui IEXEC.
    InstrOpCode = 6'h05;
    adv();
    adv();
    @(negedge clk);
    chk("bne_pcwritecond", PCWriteCond, 1);
    chk("bne_branchne", BranchNe, 1);
    chk("bne_aluop", ALUOpSignal, 1);
    adv();
    InstrOpCode = 6'h0F;
    adv();
    adv();
    @(negedge clk);
    chk("lui_state", StateOut, 10);
    chk("lui_aluop", ALUOpSignal, 7);
    chk("lui_alusrcb", ALUSrcB, 2);
    adv();
    adv();

    // Illegal opcode trap is sticky and silent until reset.
    do_reset();
    InstrOpCode = 6'h3F;
    adv();
    adv();
    @(negedge clk);
    chk("ill_state", StateOut, 11);
    chk("ill_flag", Illegal, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      adv();
      MemReady = $urandom_range(0, 1);
      InstrOpCode = 6'($urandom);
      @(negedge clk);
      if (PCWrite || PCWriteCond || MemRead || MemWrite || IRWrite ||
          RegWrite || InstrDone || !Illegal) bad++;
    end
    chk("ill_quiet_cycles", bad, 0);
`ifdef MCFSM_PERF_CNT_EN
    chk("ill_cyc_frozen", CycleCnt, 2);
    chk("ill_instr_frozen", InstrCnt, 0);
`endif
    adv();
    do_reset();
    @(negedge clk);
    chk("ill_cleared", Illegal, 0);
    chk("ill_back_fetch", StateOut, 0);

    // sw aborted by reset during a MEMWR stall.
    do_reset();
    InstrOpCode = 6'h2B;
    adv();
    adv();
    adv();
    MemReady = 1'b0;
    @(negedge clk);
    chk("sw_memwr_state", StateOut, 5);
    chk("sw_memwrite", MemWrite, 1);
    adv();
    rst = 1'b1;
    @(negedge clk);
    chk("sw_still_wait", MemWrite, 1);
    adv();
    rst = 1'b0;
    @(negedge clk);
    chk("sw_abort_memwrite", MemWrite, 0);
    chk("sw_abort_state", StateOut, 0);

`ifdef MCFSM_PERF_CNT_EN
    // Three R-type instructions: 12 cycles, 3 retired.
    do_reset();
    InstrOpCode = 6'h00;
    MemReady = 1'b1;
    for (int i = 0; i < 12; i++) adv();
    @(negedge clk);
    chk("perf_instr", InstrCnt, 3);
    chk("perf_cycle", CycleCnt, 12);
`endif

    // Randomized legal instruction stream against the model.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      op = legal[$urandom_range(0, 16)];
      if ($urandom_range(0, 9) == 0) op = 6'h03;
      run_model(op);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
